maxpool2x2_stream: RTL and testbench



---
 rtl/maxpool2x2_stream.sv | 164 ++++++++++++++++
 tb/tb_maxpool2x2_stream.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// -----------------------------------------------------------------------------
// maxpool2x2_stream
//   Streaming 2x2 / stride-2 max-pool stage for a square feature map that
//   arrives in raster order. Only partial maxima are kept: a pair-hold register
//   for the even column of the current pair, and a line buffer of IN_SIZE/2
//   pair maxima from the even row of the current window row. Results go out
//   through a one-deep valid/ready output register.
//
// Parameters
//   WIDTH_BIT  signed pixel width (input and output)
//   IN_SIZE    input feature-map side, >= 2 (odd sizes floor-pool)
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   in_data valid
//   in_ready   stage accepts in_data this cycle
//   in_data    signed input pixel
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   out_data   signed pooled pixel
//   out_last   last pooled pixel of the frame
//   done       one-cycle pulse the cycle after the frame's final pixel is accepted
//
// Build option
//   MAXPOOL_RELU_EN  when defined, negative input pixels are clamped to 0
//                    before pooling (fused ReLU).
// -----------------------------------------------------------------------------
module maxpool2x2_stream #(
    parameter int WIDTH_BIT = 16,
    parameter int IN_SIZE   = 318
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_BIT-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_BIT-1:0] out_data,
    output logic                 out_last,
    output logic                 done
);

    localparam int HALF = IN_SIZE / 2;
    localparam int CW   = $clog2(IN_SIZE);
    localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CW-1:0] LAST_IDX = CW'(IN_SIZE - 1);
    // Last row/col that belongs to a complete window (drops the odd tail).
    localparam logic [CW-1:0] WIN_LAST = CW'(2 * HALF - 1);

    logic [CW-1:0]                col_q, col_d;
    logic [CW-1:0]                row_q, row_d;
    logic signed [WIDTH_BIT-1:0]  hold_q, hold_d;
    logic signed [WIDTH_BIT-1:0]  linebuf_q [HALF];

    logic                         out_valid_q, out_valid_d;
    logic signed [WIDTH_BIT-1:0]  out_data_q, out_data_d;
    logic                         out_last_q, out_last_d;
    logic                         done_q, done_d;

    logic signed [WIDTH_BIT-1:0]  pix;
    logic signed [WIDTH_BIT-1:0]  pairmax;
    logic signed [WIDTH_BIT-1:0]  winmax;
    logic signed [WIDTH_BIT-1:0]  lb_rd;
    logic [AW-1:0]                lb_idx;
    logic                         accept;
    logic                         in_win;
    logic                         lb_we;
    logic                         load;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
`ifdef MAXPOOL_RELU_EN
        if (in_data[WIDTH_BIT-1]) begin
            pix = '0;
        end else begin
            pix = $signed(in_data);
        end
`else
        pix = $signed(in_data);
`endif
    end

    assign in_win  = (col_q <= WIN_LAST) && (row_q <= WIN_LAST);
    assign lb_idx  = AW'(col_q >> 1);
    assign lb_rd   = linebuf_q[lb_idx];
    assign pairmax = (pix > hold_q) ? pix : hold_q;
    assign winmax  = (lb_rd > pairmax) ? lb_rd : pairmax;

    // Odd column closes a pair: even row parks it, odd row closes the window.
    assign lb_we = accept && in_win && col_q[0] && !row_q[0];
    assign load  = accept && in_win && col_q[0] && row_q[0];

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        if (accept) begin
            if (!col_q[0]) begin
                hold_d = pix;
            end
            if (col_q == LAST_IDX) begin
                col_d = '0;
                row_d = (row_q == LAST_IDX) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            done_d = (row_q == LAST_IDX) && (col_q == LAST_IDX);
        end

        // A load can only happen when in_ready, so it never overwrites
        // an output that is still waiting for the consumer.
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = winmax;
            out_last_d  = (row_q == WIN_LAST) && (col_q == WIN_LAST);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    // Not reset: every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clock) begin
        if (lb_we) begin
            linebuf_q[lb_idx] <= pairmax;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// -----------------------------------------------------------------------------
// tb_maxpool2x2_stream
//   Two instances: index 0 with IN_SIZE=4, index 1 with IN_SIZE=5. Frames are
//   queued as pixel lists; expected pooled outputs are computed directly from
//   the 2x2 window definition and compared at each output handshake.
// -----------------------------------------------------------------------------
module tb_maxpool2x2_stream;

    logic        clock;
    logic        reset;
    logic        iv   [2];
    logic        ir   [2];
    logic [15:0] id   [2];
    logic        ov   [2];
    logic        ordy [2];
    logic [15:0] od   [2];
    logic        ol   [2];
    logic        dn   [2];

    int errors = 0;
    int checks = 0;

    int pix_q[$];
    bit plast_q[$];
    int exp_q[$];
    bit explast_q[$];
    int done_cnt, last_cnt, out_cnt;

    maxpool2x2_stream #(.WIDTH_BIT(16), .IN_SIZE(4)) dut4 (
        .clock(clock), .reset(reset),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .out_last(ol[0]), .done(dn[0])
    );

    maxpool2x2_stream #(.WIDTH_BIT(16), .IN_SIZE(5)) dut5 (
        .clock(clock), .reset(reset),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .out_last(ol[1]), .done(dn[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int relu(input int v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // kind 0: ramp, 1: all -3, 2: random signed
    task automatic push_frame(input int d, input int kind);
        int n, h, m, v;
        int f[];
        n = (d == 0) ? 4 : 5;
        h = n / 2;
        f = new[n * n];
        for (int i = 0; i < n * n; i++) begin
            case (kind)
                0:       f[i] = i;
                1:       f[i] = -3;
                default: f[i] = int'($urandom_range(0, 65535)) - 32768;
            endcase
            pix_q.push_back(f[i]);
            plast_q.push_back(i == n * n - 1);
        end
        for (int wr = 0; wr < h; wr++) begin
            for (int wc = 0; wc < h; wc++) begin
                m = relu(f[(2 * wr) * n + 2 * wc]);
                for (int a = 0; a < 2; a++) begin
                    for (int b = 0; b < 2; b++) begin
                        v = relu(f[(2 * wr + a) * n + 2 * wc + b]);
                        if (v > m) m = v;
                    end
                end
                exp_q.push_back(m);
                explast_q.push_back((wr == h - 1) && (wc == h - 1));
            end
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle(input int d, input bit stalling, input bit nobub);
        bit acc, hs, lastpix, hold;
        int hold_data, hold_last, v;
        #1;
        chk("in_ready_rule", int'(ir[d]), int'(!ov[d] || ordy[d]));
        if (stalling) chk("stall_in_ready", int'(ir[d]), 0);
        acc = iv[d] && ir[d];
        hs  = ov[d] && ordy[d];
        if (nobub && pix_q.size() > 0) chk("no_bubble", int'(acc), 1);
        if (hs) begin
            out_cnt++;
            if (ol[d]) last_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_out", int'($signed(od[d])), -99999);
            end else begin
                v = exp_q.pop_front();
                chk("out_data", int'($signed(od[d])), v);
                chk("out_last", int'(ol[d]), int'(explast_q.pop_front()));
            end
        end
        lastpix = 1'b0;
        if (acc) begin
            void'(pix_q.pop_front());
            lastpix = plast_q.pop_front();
        end
        hold      = ov[d] && !ordy[d];
        hold_data = int'(od[d]);
        hold_last = int'(ol[d]);
        @(posedge clock);
        @(negedge clock);
        if (dn[d]) done_cnt++;
        chk("done", int'(dn[d]), int'(lastpix));
        if (lastpix && d == 0) chk("done_with_last", int'(ov[d] && ol[d]), 1);
        if (hold) begin
            chk("hold_valid", int'(ov[d]), 1);
            chk("hold_data", int'(od[d]), hold_data);
            chk("hold_last", int'(ol[d]), hold_last);
        end
    endtask

    task automatic run(input int d, input int vp, input int rp, input int stall);
        int budget;
        bit nobub, stalling;
        budget = 4000;
        nobub  = (vp >= 100) && (rp >= 100) && (stall == 0);
        while ((pix_q.size() > 0 || exp_q.size() > 0) && budget > 0) begin
            iv[d] = (pix_q.size() > 0) && ($urandom_range(0, 99) < vp);
            id[d] = (pix_q.size() > 0) ? 16'(pix_q[0]) : 16'h0;
            stalling = 1'b0;
            if (stall > 0 && ov[d]) begin
                ordy[d]  = 1'b0;
                stall--;
                stalling = 1'b1;
            end else begin
                ordy[d] = ($urandom_range(0, 99) < rp);
            end
            cycle(d, stalling, nobub);
            budget--;
        end
        chk("run_timeout", int'(budget > 0), 1);
        iv[d]   = 1'b0;
        ordy[d] = 1'b1;
        pix_q.delete(); plast_q.delete(); exp_q.delete(); explast_q.delete();
    endtask

    task automatic check_reset_state(input int d);
        chk("rst_out_valid", int'(ov[d]), 0);
        chk("rst_out_data", int'(od[d]), 0);
        chk("rst_out_last", int'(ol[d]), 0);
        chk("rst_done", int'(dn[d]), 0);
        chk("rst_in_ready", int'(ir[d]), 1);
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; id[d] = '0; ordy[d] = 1'b1;
        end
        repeat (3) @(negedge clock);
        check_reset_state(0);
        check_reset_state(1);
        reset = 1'b0;

        // Ramp, full throughput: 5, 7, 13, 15
        push_frame(0, 0);
        run(0, 100, 100, 0);

        // All -3
        push_frame(0, 1);
        run(0, 100, 100, 0);

        // Ramp with the first output stalled for 5 cycles
        push_frame(0, 0);
        run(0, 100, 100, 5);

        // IN_SIZE=5 ramp: 6, 8, 16, 18
        push_frame(1, 0);
        run(1, 100, 100, 0);

        // Reset mid-frame with a pending output
        for (int i = 0; i < 6; i++) begin
            iv[0] = 1'b1; id[0] = 16'(i); ordy[0] = 1'b0;
            @(posedge clock);
            @(negedge clock);
        end
        chk("pending_before_reset", int'(ov[0]), 1);
        iv[0] = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        ordy[0] = 1'b1;
        check_reset_state(0);
        push_frame(0, 0);
        run(0, 100, 100, 0);

        // Two back-to-back ramp frames
        done_cnt = 0; last_cnt = 0; out_cnt = 0;
        push_frame(0, 0);
        push_frame(0, 0);
        run(0, 100, 100, 0);
        chk("b2b_done_count", done_cnt, 2);
        chk("b2b_last_count", last_cnt, 2);
        chk("b2b_out_count", out_cnt, 8);

        // Random data with random handshakes
        for (int k = 0; k < 6; k++) push_frame(0, 2);
        run(0, 70, 60, 0);
        for (int k = 0; k < 4; k++) push_frame(1, 2);
        run(1, 60, 80, 0);
        for (int k = 0; k < 3; k++) push_frame(0, 2);
        run(0, 100, 100, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
